// File: rtl/bist_sequencer.sv
// BIST sequencer: LFSR pattern source driving a CUT, MISR compaction of its
// response, and a pass/fail verdict against a golden signature after N_PAT patterns.
module bist_sequencer #(
    parameter int          IN_W   = 16,
    parameter int          OUT_W  = 16,
    parameter int          N_PAT  = 256,
    parameter int          SETTLE = 2,
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter logic [15:0] GOLDEN = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  cut_in,
    input  logic [OUT_W-1:0] cut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      signature,
    output logic [15:0]      pat_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_SETTLE, S_CAPTURE, S_DONE
    } state_t;

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [15:0] N_PAT_W     = 16'(N_PAT);

    state_t      r_state, w_next;
    logic [15:0] r_lfsr, r_misr, r_pat_cnt;
    logic [7:0]  r_settle;
    logic        r_pass;

    logic [15:0] w_cut_ext, w_misr_nxt, w_lfsr_nxt, w_cnt_nxt;
    logic        w_last;

    always_comb begin
        w_cut_ext = '0;
        w_cut_ext[OUT_W-1:0] = cut_out;
    end

    assign w_misr_nxt = {r_misr[14:0], 1'b0} ^ (r_misr[15] ? 16'h1021 : 16'h0000) ^ w_cut_ext;
    assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_cnt_nxt  = r_pat_cnt + 16'd1;
    assign w_last     = (w_cnt_nxt == N_PAT_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // abort outranks everything except in IDLE, where only start is sampled
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_INIT;
            S_INIT:    w_next = abort ? S_IDLE : S_SETTLE;
            S_SETTLE:  if (abort) w_next = S_IDLE;
                       else if (r_settle == SETTLE_LAST) w_next = S_CAPTURE;
            S_CAPTURE: if (abort) w_next = S_IDLE;
                       else w_next = w_last ? S_DONE : S_SETTLE;
            S_DONE:    if (abort) w_next = S_IDLE;
                       else if (start) w_next = S_INIT;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_INIT) || (r_state == S_SETTLE) || (r_state == S_CAPTURE);
        done = (r_state == S_DONE);
    end

    // Datapath freezes on abort so a cancelled run's progress stays observable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr    <= SEED;
            r_misr    <= '0;
            r_pat_cnt <= '0;
            r_settle  <= '0;
            r_pass    <= 1'b0;
        end else begin
            if (w_next != S_DONE)
                r_pass <= 1'b0;
            else if (r_state == S_CAPTURE)
                r_pass <= (w_misr_nxt == GOLDEN);

            if (!abort) begin
                case (r_state)
                    S_INIT: begin
                        r_lfsr    <= SEED;
                        r_misr    <= '0;
                        r_pat_cnt <= '0;
                        r_settle  <= '0;
                    end
                    S_SETTLE:  r_settle <= r_settle + 8'd1;
                    S_CAPTURE: begin
                        r_lfsr    <= w_lfsr_nxt;
                        r_misr    <= w_misr_nxt;
                        r_pat_cnt <= w_cnt_nxt;
                        r_settle  <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cut_in    = r_lfsr[IN_W-1:0];
    assign signature = r_misr;
    assign pat_cnt   = r_pat_cnt;
    assign pass      = r_pass;

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench: four sequencer instances with different run lengths/goldens
// share one start/abort/reset stimulus and are checked cycle by cycle.
module tb_bist_sequencer;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic [15:0] one = 16'h0001;

    logic [15:0] ci0, ci1, ci2, ci3, sg0, sg1, sg2, sg3, pc0, pc1, pc2, pc3;
    logic        b0, b1, b2, b3, d0, d1, d2, d3, p0, p1, p2, p3;

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] m_pat [4];
    logic [15:0] m_sig;

    always #5 clk = ~clk;

    bist_sequencer #(.N_PAT(1), .SETTLE(1), .GOLDEN(16'h0001)) u0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cut_in(ci0), .cut_out(one),
        .busy(b0), .done(d0), .pass(p0), .signature(sg0), .pat_cnt(pc0));
    bist_sequencer #(.N_PAT(2), .SETTLE(1), .GOLDEN(16'h0003)) u1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cut_in(ci1), .cut_out(one),
        .busy(b1), .done(d1), .pass(p1), .signature(sg1), .pat_cnt(pc1));
    bist_sequencer #(.N_PAT(2), .SETTLE(1), .GOLDEN(16'h0004)) u2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cut_in(ci2), .cut_out(one),
        .busy(b2), .done(d2), .pass(p2), .signature(sg2), .pat_cnt(pc2));
    bist_sequencer #(.N_PAT(4), .SETTLE(2)) u3 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cut_in(ci3), .cut_out(ci3),
        .busy(b3), .done(d3), .pass(p3), .signature(sg3), .pat_cnt(pc3));

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [15:0] d);
        return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pulse start, then sample after edges j=0..15 (j=0 is the edge sampling start).
    task automatic run(input bit first);
        int bcnt;
        bcnt = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int j = 0; j <= 15; j++) begin
            if (j > 0) @(negedge clk);
            if (b3) bcnt++;
            if (j >= 1 && j <= 12) chk("u3_cut_in", ci3, m_pat[(j-1)/3]);
            if (j <= 12) chk("u3_done_low", d3, 0);
            if (j == 13) begin
                chk("u3_done", d3, 1);
                chk("u3_sig", sg3, m_sig);
                chk("u3_pat_cnt", pc3, 4);
                chk("u3_pass", p3, (m_sig == 16'h0000));
            end
            if (first) begin
                case (j)
                    0: chk("u0_busy_rise", b0, 1);
                    1: chk("u0_cut_in_settle", ci0, 16'hACE1);
                    2: begin
                        chk("u0_done_early", d0, 0);
                        chk("u0_cut_in_capture", ci0, 16'hACE1);
                    end
                    3: begin
                        chk("u0_done", d0, 1);
                        chk("u0_busy_fall", b0, 0);
                        chk("u0_sig", sg0, 16'h0001);
                        chk("u0_pass", p0, 1);
                        chk("u0_pat_cnt", pc0, 1);
                        chk("u0_cut_in_next", ci0, 16'hE270);
                    end
                    4: chk("u1_done_early", d1, 0);
                    5: begin
                        chk("u1_done", d1, 1);
                        chk("u1_sig", sg1, 16'h0003);
                        chk("u1_pass", p1, 1);
                        chk("u1_pat_cnt", pc1, 2);
                        chk("u2_sig", sg2, 16'h0003);
                        chk("u2_pass", p2, 0);
                    end
                    default: ;
                endcase
            end
        end
        chk("u3_busy_cycles", bcnt, 13);
    endtask

    initial begin
        logic [15:0] l, m;
        l = 16'hACE1;
        m = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            m_pat[k] = l;
            m = misr_step(m, l);
            l = lfsr_step(l);
        end
        m_sig = m;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_pat_cnt", pc0, 0);
        chk("reset_pass", p0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_cut_in", ci0, 16'hACE1);
            chk("idle_busy", b0, 0);
            chk("idle_done", d0, 0);
            chk("idle_sig", sg0, 0);
        end

        run(1'b1);

        // abort during second pattern's SETTLE
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_pre_pat_cnt", pc3, 1);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("abort_busy", b3, 0);
        chk("abort_done", d3, 0);
        chk("abort_pat_cnt", pc3, 1);
        chk("abort_from_done", d0, 0);
        chk("abort_from_done_pass", p0, 0);
        repeat (2) @(negedge clk);
        chk("abort_stays_idle", b3, 0);

        run(1'b0);

        // reset asserted in CAPTURE
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_capture_busy", b3, 1);
        rst = 1'b1;
        #1;
        chk("rst_cut_in", ci3, 16'hACE1);
        chk("rst_busy", b3, 0);
        chk("rst_done", d3, 0);
        chk("rst_sig", sg3, 0);
        chk("rst_pat_cnt", pc3, 0);
        chk("rst_pass", p3, 0);
        @(negedge clk) rst = 1'b0;

        run(1'b0);
        run(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
